ritc_phase_shift_responder: RTL and testbench
=============================================

Name: ritc_phase_shift_responder

Overview:
- Clock-manager side of the phase-control bus driven by the RITC dual phase scanner.
- Accepts PSEN/PSINCDEC/reset requests on the 8-bit phase-control bus and drives the MMCM dynamic-phase-shift and reset pins.
- Returns PSDONE, busy, lock and error status on the return bus.
- Tracks the absolute fine-phase position modulo one VCDL period, for servo/diagnostic readback.

Parameters:
- POS_WIDTH, 12: width of the phase position counter.
- STEPS_PER_PERIOD, 1120: fine-shift steps per VCDL period. Position wraps at this value. Must be <= 2**POS_WIDTH.
- RST_CYCLES, 8: MMCM_RST assertion length, in CLK cycles.
- LOCK_TIMEOUT, 65535: maximum CLK cycles to wait for MMCM_LOCKED after reset.
- DONE_TIMEOUT, 255: maximum CLK cycles to wait for MMCM_PSDONE after MMCM_PSEN.

Ports:
- CLK  in  1  single clock. Also the MMCM PSCLK.
- rst_i  in  1  reset, synchronous, active-high.
- phase_control_in  in  8  request bus from the scanner:
  - [0] PSEN pulse
  - [1] PSINCDEC (1 = increment)
  - [7] reset request, level
  - [6:2] ignored
- phase_control_out  out  8  return bus:
  - [0] PSDONE, 1-cycle pulse
  - [1] busy
  - [2] locked
  - [3] done_timeout_err, sticky
  - [4] lock_timeout_err, sticky
  - [7:5] 0
- MMCM_PSEN  out  1  1-cycle phase-shift enable to the MMCM.
- MMCM_PSINCDEC  out  1  direction to the MMCM. Valid with MMCM_PSEN.
- MMCM_PSDONE  in  1  MMCM shift-complete pulse.
- MMCM_RST  out  1  MMCM reset.
- MMCM_LOCKED  in  1  MMCM lock indicator.
- phase_pos_o  out  POS_WIDTH  current position, 0..STEPS_PER_PERIOD-1.
- dropped_o  out  8  saturating count of PSEN requests received while busy.

Behaviour:
- Reset (rst_i=1, sampled on CLK), next cycle:
  - state = RESET_HOLD, reset counter cleared.
  - phase_pos_o=0, dropped_o=0, error flags=0.
  - MMCM_PSEN=0, MMCM_RST=1, phase_control_out=8'h02 (busy).
- States:
  - RESET_HOLD: MMCM_RST=1 for RST_CYCLES cycles, then -> WAIT_LOCK.
  - WAIT_LOCK: MMCM_RST=0, busy=1.
    - MMCM_LOCKED=1 -> IDLE.
    - LOCK_TIMEOUT cycles elapse first -> set lock_timeout_err, -> IDLE with locked=0.
  - IDLE: busy=0.
    - PSEN=1 -> SHIFT. PSINCDEC is latched in the same cycle.
    - A rising edge on bit7 -> RESET_HOLD. Takes priority over PSEN in the same cycle.
  - SHIFT: MMCM_PSEN=1 and MMCM_PSINCDEC=latched direction for exactly one cycle, busy=1. Next state WAIT_DONE; timeout counter cleared.
  - WAIT_DONE: busy=1.
    - MMCM_PSDONE=1 -> update position, -> ACK.
    - DONE_TIMEOUT cycles elapse -> set done_timeout_err, position unchanged, -> ACK.
  - ACK: phase_control_out[0]=1 for one cycle, busy deasserts the same cycle, -> IDLE.
- Latency:
  - PSEN in at cycle N -> MMCM_PSEN at cycle N+1.
  - MMCM_PSDONE at cycle M -> PSDONE out at cycle M+1; phase_pos_o updated at M+1.
- Position arithmetic:
  - Increment: STEPS_PER_PERIOD-1 wraps to 0.
  - Decrement: 0 wraps to STEPS_PER_PERIOD-1.
  - No other arithmetic; the counter is unsigned.
- Busy and reset-request edge cases:
  - PSEN while busy (any state except IDLE) is not queued; dropped_o increments, saturating at 255.
  - Bit7 rising edge in any state other than RESET_HOLD/WAIT_LOCK aborts the operation: no PSDONE pulse, position cleared to 0, -> RESET_HOLD.
  - Bit7 held high does not retrigger. The edge detector register resets to 0, so bit7 already high at rst_i release is treated as an edge.
- MMCM_LOCKED:
  - Loss of lock in IDLE drives locked=0 but changes no state. PSEN is still honoured.
  - The scanner is responsible for issuing a reset request.
- Error flags are cleared only by rst_i or by a reset request.
- Spurious MMCM_PSDONE outside WAIT_DONE is ignored.
- rst_i mid-shift: immediate return to the reset values; any in-flight MMCM PSDONE is ignored.

Decomposition:
- Shared package ritc_phase_ctrl_pkg, also used by the scanner:
  - Bit-index constants for both 8-bit buses (PSEN=0, PSINCDEC=1, RST_REQ=7; PSDONE=0, BUSY=1, LOCKED=2, DONE_ERR=3, LOCK_ERR=4).
  - State encoding enum.
- One sub-module: ritc_ps_wrap_counter. Modulo-STEPS_PER_PERIOD up/down counter with synchronous clear.

Test Plan:
- Reset, then MMCM_LOCKED rises 20 cycles after MMCM_RST falls:
  - MMCM_RST high exactly 8 cycles.
  - busy=1 until lock; then phase_control_out=8'h04.
  - phase_pos_o=0.
- Three increments, each with MMCM_PSDONE 12 cycles after MMCM_PSEN:
  - Three MMCM_PSEN pulses with PSINCDEC=1.
  - Three PSDONE pulses, each 1 cycle after MMCM_PSDONE.
  - phase_pos_o=3.
- From position 0, one decrement -> phase_pos_o=1119. Then one increment -> 0.
- PSEN with MMCM_PSDONE withheld:
  - After 255 cycles, PSDONE pulses and done_timeout_err=1.
  - phase_pos_o unchanged.
- PSEN pulsed twice during WAIT_DONE -> dropped_o=2, only one MMCM_PSEN issued.
- Reset request (bit7 rising) during WAIT_DONE at position 5:
  - No PSDONE pulse.
  - MMCM_RST asserted next cycle.
  - phase_pos_o=0 and error flags cleared.

Source files
------------

// File: rtl/ritc_phase_ctrl_pkg.sv
// Shared definitions for the RITC phase-control bus (scanner <-> clock manager).
package ritc_phase_ctrl_pkg;

  // Request bus (scanner -> responder) bit positions
  localparam int unsigned PCI_PSEN     = 0;
  localparam int unsigned PCI_PSINCDEC = 1;
  localparam int unsigned PCI_RST_REQ  = 7;

  // Return bus (responder -> scanner) bit positions
  localparam int unsigned PCO_PSDONE   = 0;
  localparam int unsigned PCO_BUSY     = 1;
  localparam int unsigned PCO_LOCKED   = 2;
  localparam int unsigned PCO_DONE_ERR = 3;
  localparam int unsigned PCO_LOCK_ERR = 4;

  localparam int unsigned PC_BUS_W     = 8;

  // Responder state encoding
  typedef logic [2:0] ps_state_t;
  localparam ps_state_t S_RESET_HOLD = 3'd0;
  localparam ps_state_t S_WAIT_LOCK  = 3'd1;
  localparam ps_state_t S_IDLE       = 3'd2;
  localparam ps_state_t S_SHIFT      = 3'd3;
  localparam ps_state_t S_WAIT_DONE  = 3'd4;
  localparam ps_state_t S_ACK        = 3'd5;

endpackage

// File: rtl/ritc_ps_wrap_counter.sv
// Modulo-MODULUS up/down counter with synchronous clear; tracks fine-phase position.
module ritc_ps_wrap_counter #(
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned MODULUS = 1120
) (
  input  logic             CLK,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  // Clear wins, then increment, then decrement; both ends wrap.
  always_ff @(posedge CLK) begin
    if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == LAST) ? '0 : count + WIDTH'(1);
    end else if (dec) begin
      count <= (count == '0) ? LAST : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/ritc_phase_shift_responder.sv
// Clock-manager side of the RITC phase-control bus: drives MMCM dynamic phase
// shift and reset, reports status, and tracks absolute fine-phase position.
module ritc_phase_shift_responder
  import ritc_phase_ctrl_pkg::*;
#(
  parameter int unsigned POS_WIDTH        = 12,
  parameter int unsigned STEPS_PER_PERIOD = 1120,
  parameter int unsigned RST_CYCLES       = 8,
  parameter int unsigned LOCK_TIMEOUT     = 65535,
  parameter int unsigned DONE_TIMEOUT     = 255
) (
  input  logic                 CLK,
  input  logic                 rst_i,
  input  logic [7:0]           phase_control_in,
  output logic [7:0]           phase_control_out,
  output logic                 MMCM_PSEN,
  output logic                 MMCM_PSINCDEC,
  input  logic                 MMCM_PSDONE,
  output logic                 MMCM_RST,
  input  logic                 MMCM_LOCKED,
  output logic [POS_WIDTH-1:0] phase_pos_o,
  output logic [7:0]           dropped_o
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);

  ps_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q;
  logic             dir_q, dir_d;
  logic             derr_q, derr_d;
  logic             lerr_q, lerr_d;
  logic [7:0]       dropped_q, dropped_d;
  logic             rst_out_q, rst_out_d;
  logic             psen_q, psen_d;
  logic             psdone_q, psdone_d;
  logic             busy_q, busy_d;
  logic             locked_q, locked_d;

  logic             psen_req;
  logic             req_edge;
  logic             active;
  logic             abort;
  logic             pos_inc, pos_dec, pos_clr;
  logic             unused_bits;

  assign unused_bits = ^phase_control_in[6:2];

  assign psen_req = phase_control_in[PCI_PSEN];
  assign req_edge = phase_control_in[PCI_RST_REQ] & ~req_q;
  assign active   = (state_q == S_IDLE) || (state_q == S_SHIFT) ||
                    (state_q == S_WAIT_DONE) || (state_q == S_ACK);
  assign abort    = req_edge & active;

  // Next-state, counters, flags and registered-output next values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    derr_d    = derr_q;
    lerr_d    = lerr_q;
    dropped_d = dropped_q;
    pos_inc   = 1'b0;
    pos_dec   = 1'b0;
    pos_clr   = 1'b0;

    // Requests arriving while an operation is in progress are only counted
    if (psen_req && (state_q != S_IDLE) && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end

    if (abort) begin
      state_d = S_RESET_HOLD;
      cnt_d   = '0;
      pos_clr = 1'b1;
      derr_d  = 1'b0;
      lerr_d  = 1'b0;
    end else begin
      case (state_q)
        S_RESET_HOLD: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (MMCM_LOCKED) begin
            state_d = S_IDLE;
          end else if (cnt_q == LOCK_LAST) begin
            lerr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_IDLE: begin
          if (psen_req) begin
            dir_d   = phase_control_in[PCI_PSINCDEC];
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          state_d = S_WAIT_DONE;
          cnt_d   = '0;
        end
        S_WAIT_DONE: begin
          if (MMCM_PSDONE) begin
            pos_inc = dir_q;
            pos_dec = ~dir_q;
            state_d = S_ACK;
          end else if (cnt_q == DONE_LAST) begin
            derr_d  = 1'b1;
            state_d = S_ACK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_ACK: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_RESET_HOLD;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are registered, so they follow the state being entered
    rst_out_d = (state_d == S_RESET_HOLD);
    psen_d    = (state_d == S_SHIFT);
    psdone_d  = (state_d == S_ACK);
    busy_d    = !((state_d == S_IDLE) || (state_d == S_ACK));
    locked_d  = MMCM_LOCKED &&
                ((state_d == S_IDLE) || (state_d == S_SHIFT) ||
                 (state_d == S_WAIT_DONE) || (state_d == S_ACK));
  end

  // State, bookkeeping and output registers
  always_ff @(posedge CLK) begin
    if (rst_i) begin
      state_q   <= S_RESET_HOLD;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      dir_q     <= 1'b0;
      derr_q    <= 1'b0;
      lerr_q    <= 1'b0;
      dropped_q <= 8'd0;
      rst_out_q <= 1'b1;
      psen_q    <= 1'b0;
      psdone_q  <= 1'b0;
      busy_q    <= 1'b1;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= phase_control_in[PCI_RST_REQ];
      dir_q     <= dir_d;
      derr_q    <= derr_d;
      lerr_q    <= lerr_d;
      dropped_q <= dropped_d;
      rst_out_q <= rst_out_d;
      psen_q    <= psen_d;
      psdone_q  <= psdone_d;
      busy_q    <= busy_d;
      locked_q  <= locked_d;
    end
  end

  // Absolute fine-phase position
  ritc_ps_wrap_counter #(
    .WIDTH   (POS_WIDTH),
    .MODULUS (STEPS_PER_PERIOD)
  ) u_pos (
    .CLK   (CLK),
    .clr   (rst_i | pos_clr),
    .inc   (pos_inc),
    .dec   (pos_dec),
    .count (phase_pos_o)
  );

  // Return-bus assembly from registered status bits
  always_comb begin
    phase_control_out               = '0;
    phase_control_out[PCO_PSDONE]   = psdone_q;
    phase_control_out[PCO_BUSY]     = busy_q;
    phase_control_out[PCO_LOCKED]   = locked_q;
    phase_control_out[PCO_DONE_ERR] = derr_q;
    phase_control_out[PCO_LOCK_ERR] = lerr_q;
  end

  assign MMCM_PSEN     = psen_q;
  assign MMCM_PSINCDEC = dir_q;
  assign MMCM_RST      = rst_out_q;
  assign dropped_o     = dropped_q;

endmodule

// File: tb/tb_ritc_phase_shift_responder.sv
// Scoreboard bench for ritc_phase_shift_responder with a behavioural MMCM.
module tb_ritc_phase_shift_responder;

  localparam int STEPS = 1120;

  logic        CLK = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  phase_control_in = 8'h00;
  logic [7:0]  phase_control_out;
  logic        MMCM_PSEN;
  logic        MMCM_PSINCDEC;
  logic        MMCM_PSDONE;
  logic        MMCM_RST;
  logic        MMCM_LOCKED = 1'b0;
  logic [11:0] phase_pos_o;
  logic [7:0]  dropped_o;

  always #5 CLK = ~CLK;

  ritc_phase_shift_responder dut (
    .CLK               (CLK),
    .rst_i             (rst_i),
    .phase_control_in  (phase_control_in),
    .phase_control_out (phase_control_out),
    .MMCM_PSEN         (MMCM_PSEN),
    .MMCM_PSINCDEC     (MMCM_PSINCDEC),
    .MMCM_PSDONE       (MMCM_PSDONE),
    .MMCM_RST          (MMCM_RST),
    .MMCM_LOCKED       (MMCM_LOCKED),
    .phase_pos_o       (phase_pos_o),
    .dropped_o         (dropped_o)
  );

  typedef struct packed {
    logic [11:0] pos;
    logic        derr;
    logic        via_mmcm;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   mdone_cyc = -10;
  int   psen_cnt = 0;
  int   mmcm_delay = 12;
  int   pend = 0;
  logic mdl_done = 1'b0;
  logic spur_done = 1'b0;
  int   model_pos = 0;
  logic model_derr = 1'b0;

  assign MMCM_PSDONE = mdl_done | spur_done;

  // Cycle bookkeeping
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (MMCM_PSDONE) mdone_cyc <= cyc;
    if (MMCM_PSEN) psen_cnt <= psen_cnt + 1;
  end

  // MMCM model: PSDONE mmcm_delay cycles after PSEN (0 = withhold)
  always @(negedge CLK) begin
    mdl_done = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) mdl_done = 1'b1;
    end
    if (MMCM_PSEN === 1'b1 && mmcm_delay != 0) pend = mmcm_delay;
  end

  // Scoreboard: every PSDONE pulse pops one expectation
  always @(negedge CLK) begin
    if (phase_control_out[0] === 1'b1) begin
      n_tests = n_tests + 1;
      if (sb.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_psdone: got pulse at cycle %0d, want none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (phase_pos_o !== e.pos || phase_control_out[3] !== e.derr ||
            (e.via_mmcm && cyc != mdone_cyc + 1)) begin
          n_fail = n_fail + 1;
          $display("FAIL psdone_sb: got pos=%0d derr=%0b lat=%0d, want pos=%0d derr=%0b lat=1",
                   phase_pos_o, phase_control_out[3], cyc - mdone_cyc, e.pos, e.derr);
        end
      end
    end
  end

  // Issue one shift and wait for its acknowledge; exp_lat counted from MMCM_PSEN
  task automatic do_shift(input logic dir, input int exp_lat, input logic timeout);
    exp_t e;
    int   k;
    bit   seen;
    if (!timeout) model_pos = dir ? (model_pos + 1) % STEPS
                                  : ((model_pos == 0) ? STEPS - 1 : model_pos - 1);
    else model_derr = 1'b1;
    e.pos = 12'(model_pos);
    e.derr = model_derr;
    e.via_mmcm = !timeout;
    sb.push_back(e);
    phase_control_in[0] = 1'b1;
    phase_control_in[1] = dir;
    @(negedge CLK);
    phase_control_in[1:0] = 2'b00;
    n_tests++;
    if (MMCM_PSEN !== 1'b1 || MMCM_PSINCDEC !== dir) begin
      n_fail++;
      $display("FAIL mmcm_psen: got psen=%0b dir=%0b, want psen=1 dir=%0b",
               MMCM_PSEN, MMCM_PSINCDEC, dir);
    end
    k = 0;
    seen = 0;
    while (!seen && k < 400) begin
      @(negedge CLK);
      k++;
      if (k == 1) begin
        n_tests++;
        if (MMCM_PSEN !== 1'b0) begin
          n_fail++;
          $display("FAIL psen_width: got psen=%0b one cycle later, want 0", MMCM_PSEN);
        end
      end
      if (phase_control_out[0] === 1'b1) seen = 1;
    end
    n_tests++;
    if (!seen || k != exp_lat) begin
      n_fail++;
      $display("FAIL psdone_latency: got %0d cycles (seen=%0b), want %0d", k, seen, exp_lat);
    end
    n_tests++;
    if (phase_control_out[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_at_ack: got busy=%0b, want 0", phase_control_out[1]);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    int n;
    bit bad;
    rst_i = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (phase_control_out !== 8'h02 || MMCM_RST !== 1'b1 || MMCM_PSEN !== 1'b0 ||
        phase_pos_o !== 12'd0 || dropped_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: got out=%h rst=%b psen=%b pos=%0d drop=%0d, want 02 1 0 0 0",
               phase_control_out, MMCM_RST, MMCM_PSEN, phase_pos_o, dropped_o);
    end
    rst_i = 1'b0;
    n = 0;
    while (MMCM_RST === 1'b1 && n < 50) begin
      n++;
      @(negedge CLK);
    end
    n_tests++;
    if (n != 8) begin
      n_fail++;
      $display("FAIL mmcm_rst_len: got %0d cycles, want 8", n);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (phase_control_out !== 8'h02) bad = 1;
      @(negedge CLK);
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL wait_lock_busy: got status other than 02 while unlocked, want 02");
    end
    MMCM_LOCKED = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (phase_control_out !== 8'h04 || phase_pos_o !== 12'd0) begin
      n_fail++;
      $display("FAIL locked_idle: got out=%h pos=%0d, want 04 0", phase_control_out, phase_pos_o);
    end
  endtask

  task automatic test_increments();
    int p0;
    mmcm_delay = 12;
    p0 = psen_cnt;
    for (int i = 0; i < 3; i++) do_shift(1'b1, 13, 1'b0);
    n_tests++;
    if (phase_pos_o !== 12'd3 || psen_cnt - p0 != 3) begin
      n_fail++;
      $display("FAIL three_inc: got pos=%0d psens=%0d, want 3 3", phase_pos_o, psen_cnt - p0);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) do_shift(1'b0, 13, 1'b0);
    n_tests++;
    if (phase_pos_o !== 12'd0) begin
      n_fail++;
      $display("FAIL back_to_zero: got %0d, want 0", phase_pos_o);
    end
    do_shift(1'b0, 13, 1'b0);
    n_tests++;
    if (phase_pos_o !== 12'd1119) begin
      n_fail++;
      $display("FAIL dec_wrap: got %0d, want 1119", phase_pos_o);
    end
    do_shift(1'b1, 13, 1'b0);
    n_tests++;
    if (phase_pos_o !== 12'd0) begin
      n_fail++;
      $display("FAIL inc_wrap: got %0d, want 0", phase_pos_o);
    end
  endtask

  task automatic test_done_timeout();
    mmcm_delay = 0;
    // one SHIFT cycle plus 255 WAIT_DONE cycles before the acknowledge
    do_shift(1'b1, 256, 1'b1);
    n_tests++;
    if (phase_pos_o !== 12'd0 || phase_control_out !== 8'h0C) begin
      n_fail++;
      $display("FAIL done_timeout: got pos=%0d out=%h, want 0 0c", phase_pos_o, phase_control_out);
    end
    mmcm_delay = 12;
  endtask

  task automatic test_dropped();
    exp_t e;
    int   p0;
    int   k;
    p0 = psen_cnt;
    model_pos = (model_pos + 1) % STEPS;
    e.pos = 12'(model_pos);
    e.derr = model_derr;
    e.via_mmcm = 1'b1;
    sb.push_back(e);
    phase_control_in = 8'h03;
    @(negedge CLK);
    phase_control_in = 8'h00;
    @(negedge CLK);
    phase_control_in[0] = 1'b1;
    @(negedge CLK);
    phase_control_in[0] = 1'b0;
    @(negedge CLK);
    phase_control_in[0] = 1'b1;
    @(negedge CLK);
    phase_control_in[0] = 1'b0;
    k = 0;
    while (phase_control_out[0] !== 1'b1 && k < 400) begin
      @(negedge CLK);
      k++;
    end
    @(negedge CLK);
    n_tests++;
    if (dropped_o !== 8'd2 || psen_cnt - p0 != 1 || phase_pos_o !== 12'd1) begin
      n_fail++;
      $display("FAIL dropped: got drop=%0d psens=%0d pos=%0d, want 2 1 1",
               dropped_o, psen_cnt - p0, phase_pos_o);
    end
  endtask

  task automatic test_reset_request();
    int n;
    bit bad;
    for (int i = 0; i < 4; i++) do_shift(1'b1, 13, 1'b0);
    n_tests++;
    if (phase_pos_o !== 12'd5) begin
      n_fail++;
      $display("FAIL pos_five: got %0d, want 5", phase_pos_o);
    end
    phase_control_in = 8'h03;
    @(negedge CLK);
    phase_control_in = 8'h00;
    @(negedge CLK);
    @(negedge CLK);
    phase_control_in[7] = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (MMCM_RST !== 1'b1 || phase_pos_o !== 12'd0 || phase_control_out !== 8'h02) begin
      n_fail++;
      $display("FAIL req_abort: got rst=%b pos=%0d out=%h, want 1 0 02",
               MMCM_RST, phase_pos_o, phase_control_out);
    end
    model_pos = 0;
    model_derr = 1'b0;
    n = 0;
    while (MMCM_RST === 1'b1 && n < 50) begin
      n++;
      @(negedge CLK);
    end
    n_tests++;
    if (n != 8) begin
      n_fail++;
      $display("FAIL req_rst_len: got %0d cycles, want 8", n);
    end
    @(negedge CLK);
    n_tests++;
    if (phase_control_out !== 8'h04) begin
      n_fail++;
      $display("FAIL req_relock: got out=%h, want 04", phase_control_out);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (MMCM_RST !== 1'b0) bad = 1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL req_level_retrigger: got MMCM_RST=1 with bit7 held, want 0");
    end
    phase_control_in[7] = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_lock_loss();
    MMCM_LOCKED = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (phase_control_out !== 8'h00) begin
      n_fail++;
      $display("FAIL lock_loss: got out=%h, want 00", phase_control_out);
    end
    do_shift(1'b1, 13, 1'b0);
    n_tests++;
    if (phase_pos_o !== 12'd1 || phase_control_out !== 8'h00) begin
      n_fail++;
      $display("FAIL shift_unlocked: got pos=%0d out=%h, want 1 00", phase_pos_o, phase_control_out);
    end
    MMCM_LOCKED = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (phase_control_out !== 8'h04) begin
      n_fail++;
      $display("FAIL relock_idle: got out=%h, want 04", phase_control_out);
    end
  endtask

  task automatic test_spurious_done();
    spur_done = 1'b1;
    @(negedge CLK);
    spur_done = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    n_tests++;
    if (phase_pos_o !== 12'(model_pos) || phase_control_out !== 8'h04) begin
      n_fail++;
      $display("FAIL spurious_done: got pos=%0d out=%h, want %0d 04",
               phase_pos_o, phase_control_out, model_pos);
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_increments();
    test_wrap();
    test_done_timeout();
    test_dropped();
    test_reset_request();
    test_lock_loss();
    test_spurious_done();
    repeat (20) @(negedge CLK);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d outstanding, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
